spi_target_fifo: RTL and testbench
==================================

SPI_TARGET_FIFO -- requirements
Module: spi_target_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, word length in bits (2..32).
REQ-002 SHALL have parameter DEPTH, default 4, RX FIFO depth in words (power of 2, >= 2).
REQ-003 SHALL have parameter CPOL, default 0, idle level of sck.
REQ-004 SHALL have parameter CPHA, default 0, 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-005 SHALL have parameter MSB_FIRST, default 1, 1 = MSB shifted first on both sdi and sdo.
REQ-006 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth for sck/sdi/ce (>= 2).
REQ-007 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-008 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-009 SHALL have port sck  input  1  SPI clock from controller, asynchronous to clk.
REQ-010 SHALL have port sdi  input  1  serial data in.
REQ-011 SHALL have port sdo  output  1  serial data out.
REQ-012 SHALL have port ce  input  1  chip enable, active-high, asynchronous.
REQ-013 SHALL have port tx_data  input  WIDTH  word transmitted on sdo, captured at each word start.
REQ-014 SHALL have port rx_data  output  WIDTH  FIFO head word, first-word fall-through.
REQ-015 SHALL have port rx_valid  output  1  FIFO not empty.
REQ-016 SHALL have port rx_ready  input  1  pop request; pop occurs when rx_valid && rx_ready.
REQ-017 SHALL have port rx_count  output  $clog2(DEPTH)+1  words held in FIFO.
REQ-018 SHALL have port overflow  output  1  sticky flag, word dropped on full FIFO.
REQ-019 SHALL have port ovf_clr  input  1  synchronous clear of overflow.
REQ-020 SHALL have port busy  output  1  high while in ACTIVE state.

Function
REQ-021 SHALL pass sck, sdi, ce through SYNC_STAGES flops each; all logic uses synchronised copies only.
REQ-022 SHALL detect sck edges by comparing synchronised sck against its one-cycle-delayed copy; leading edge = rising when CPOL=0, falling when CPOL=1.
REQ-023 SHALL use the sample edge = leading edge if CPHA=0, trailing edge otherwise; shift edge = the other edge.
REQ-024 SHALL implement FSM IDLE -> ACTIVE on synchronised ce rising; ACTIVE -> IDLE on synchronised ce low; no other states.
REQ-025 On entry to ACTIVE: bit counter = 0, TX shift register loaded from tx_data, sdo = first TX bit in the same cycle.
REQ-026 On each sample edge in ACTIVE: shift synchronised sdi into RX register (MSB_FIRST selects direction), bit counter += 1.
REQ-027 On each shift edge in ACTIVE: advance TX register; with CPHA=1 the first shift edge of a word is ignored so bit 0 is held for the first sample.
REQ-028 On the WIDTH-th sample edge: completed word pushed to FIFO in that cycle, counter wraps to 0, TX register reloaded from tx_data; back-to-back words within one ce frame supported.
REQ-029 ce deasserted mid-word: partial word discarded, no push, counter cleared, overflow unchanged.
REQ-030 Push when FIFO full and no pop in same cycle: word dropped, overflow set; overflow stays set until ovf_clr is high (clear wins over simultaneous set).
REQ-031 Simultaneous push and pop when full: both accepted, rx_count unchanged, overflow not set.
REQ-032 rx_valid and rx_count SHALL reflect a push in the cycle after the final sample edge is detected.
REQ-033 sdo SHALL drive 0 in IDLE; the block has no tri-state output.
REQ-034 Correct operation SHALL require each sck high and low phase >= SYNC_STAGES+2 clk periods; faster sck is unsupported.

Reset
REQ-035 reset low SHALL asynchronously force: FSM IDLE, counter 0, FIFO empty (rx_count 0, rx_valid 0), rx_data 0, overflow 0, busy 0, sdo 0, synchronisers to CPOL / 0 / 0.
REQ-036 reset asserted mid-word SHALL discard the partial word; after release the block waits for a fresh synchronised ce rising edge.

Verification
REQ-037 Mode 0, WIDTH=8: ce high, shift 0xA5 on sdi, tx_data=0x3C -> FIFO holds 0xA5, sdo sequence 0,0,1,1,1,1,0,0.
REQ-038 Each of modes 1, 2, 3 with byte 0x96, MSB_FIRST=0 -> rx_data 0x96, sdo matches tx_data LSB-first.
REQ-039 One ce frame of 5 bytes 0x01..0x05, rx_ready=0, DEPTH=4 -> rx_count 4, FIFO 0x01..0x04, overflow 1; pulse ovf_clr -> overflow 0.
REQ-040 ce dropped after 5 bits, then full byte 0x7E -> only 0x7E pushed, rx_count 1.
REQ-041 FIFO full, rx_ready=1 held during next push -> rx_count stays 4, overflow 0, order preserved.
REQ-042 reset low after 3 bits of a word -> all outputs at reset values; next full frame with 0xC3 -> single word 0xC3.

Source files
------------

// File: rtl/spi_target_fifo.sv
// -----------------------------------------------------------------------------
// spi_target_fifo
//
// SPI target (peripheral) with a receive FIFO. The SPI pins are sampled in the
// system clock domain through synchronisers. sck edges are then recovered by
// comparing the synchronised sck with a one-cycle-delayed copy. While ce is
// high, words are shifted in on sdi and shifted out on sdo. A frame may carry
// any number of back-to-back words. Each completed word is pushed into a
// first-word-fall-through FIFO.
//
// Parameters
//   WIDTH        word length in bits (2..32)
//   DEPTH        RX FIFO depth in words (power of 2, >= 2)
//   CPOL         idle level of sck
//   CPHA         0: sample on leading edge, 1: sample on trailing edge
//   MSB_FIRST    1: MSB first on both sdi and sdo
//   SYNC_STAGES  synchroniser depth for sck/sdi/ce (>= 2)
//
// Ports
//   clk       system clock, rising edge
//   reset     asynchronous, active-low reset
//   sck       SPI clock from the controller (asynchronous)
//   sdi       serial data in
//   sdo       serial data out (driven 0 while idle, never tri-stated)
//   ce        chip enable, active high (asynchronous)
//   tx_data   word to transmit, captured at the start of every word
//   rx_data   FIFO head word (0 when the FIFO is empty)
//   rx_valid  FIFO not empty
//   rx_ready  pop request; a pop happens when rx_valid && rx_ready
//   rx_count  number of words held in the FIFO
//   overflow  sticky flag: a completed word was dropped on a full FIFO
//   ovf_clr   synchronous clear of overflow (wins over a simultaneous set)
//   busy      high while a ce frame is active
//
// Handshake: rx_data/rx_valid describe the FIFO head. A word is consumed on
// every rising clk edge where rx_valid and rx_ready are both high. rx_ready
// may be held high without a word being present.
// -----------------------------------------------------------------------------
module spi_target_fifo #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int MSB_FIRST   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sck,
    input  logic                     sdi,
    output logic                     sdo,
    input  logic                     ce,
    input  logic [WIDTH-1:0]         tx_data,
    output logic [WIDTH-1:0]         rx_data,
    output logic                     rx_valid,
    input  logic                     rx_ready,
    output logic [$clog2(DEPTH):0]   rx_count,
    output logic                     overflow,
    input  logic                     ovf_clr,
    output logic                     busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(WIDTH);

    localparam logic CPOL_B = (CPOL != 0);
    localparam logic CPHA_B = (CPHA != 0);
    localparam logic MSB_B  = (MSB_FIRST != 0);

    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers and edge recovery
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] sdi_sync_q;
    logic [SYNC_STAGES-1:0] ce_sync_q;
    logic                   sck_prev_q;
    logic                   ce_prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sck_sync_q <= {SYNC_STAGES{CPOL_B}};
            sdi_sync_q <= '0;
            ce_sync_q  <= '0;
            sck_prev_q <= CPOL_B;
            ce_prev_q  <= 1'b0;
        end else begin
            sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck};
            sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], sdi};
            ce_sync_q  <= {ce_sync_q[SYNC_STAGES-2:0], ce};
            sck_prev_q <= sck_sync_q[SYNC_STAGES-1];
            ce_prev_q  <= ce_sync_q[SYNC_STAGES-1];
        end
    end

    logic sck_s, sdi_s, ce_s;
    logic sck_rise, sck_fall, lead_edge, trail_edge;
    logic sample_edge, shift_edge, ce_rise;

    assign sck_s = sck_sync_q[SYNC_STAGES-1];
    assign sdi_s = sdi_sync_q[SYNC_STAGES-1];
    assign ce_s  = ce_sync_q[SYNC_STAGES-1];

    assign sck_rise    = sck_s & ~sck_prev_q;
    assign sck_fall    = ~sck_s & sck_prev_q;
    assign lead_edge   = CPOL_B ? sck_fall : sck_rise;
    assign trail_edge  = CPOL_B ? sck_rise : sck_fall;
    assign sample_edge = CPHA_B ? trail_edge : lead_edge;
    assign shift_edge  = CPHA_B ? lead_edge : trail_edge;
    assign ce_rise     = ce_s & ~ce_prev_q;

    // ------------------------------------------------------------------
    // Shift engine
    // ------------------------------------------------------------------
    state_t           state_q;
    logic [BW-1:0]    bit_cnt_q;
    logic [WIDTH-1:0] rx_sr_q;
    logic [WIDTH-1:0] tx_sr_q;
    logic             sdo_q;
    // Set when the next shift edge must leave sdo untouched. With CPHA=1
    // this edge is the leading edge that opens each word. With CPHA=0 it is
    // the trailing edge that follows the last sample. At that point the
    // freshly loaded bit 0 of the next word is already on sdo.
    logic             skip_q;

    logic [WIDTH-1:0] rx_shifted;
    logic [WIDTH-1:0] tx_shifted;
    logic             word_done;

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        first_bit = MSB_B ? w[WIDTH-1] : w[0];
    endfunction

    assign rx_shifted = MSB_B ? {rx_sr_q[WIDTH-2:0], sdi_s}
                              : {sdi_s, rx_sr_q[WIDTH-1:1]};
    assign tx_shifted = MSB_B ? {tx_sr_q[WIDTH-2:0], 1'b0}
                              : {1'b0, tx_sr_q[WIDTH-1:1]};

    // The final sample edge of a word pushes the fully shifted value in the
    // same cycle, so the FIFO reflects it one cycle after edge detection.
    assign word_done = (state_q == ST_ACTIVE) && ce_s && sample_edge
                       && (bit_cnt_q == LAST_BIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            rx_sr_q   <= '0;
            tx_sr_q   <= '0;
            sdo_q     <= 1'b0;
            skip_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    sdo_q <= 1'b0;
                    if (ce_rise) begin
                        state_q   <= ST_ACTIVE;
                        bit_cnt_q <= '0;
                        rx_sr_q   <= '0;
                        tx_sr_q   <= tx_data;
                        sdo_q     <= first_bit(tx_data);
                        skip_q    <= CPHA_B;
                    end
                end
                ST_ACTIVE: begin
                    if (!ce_s) begin
                        // Frame closed: any partial word is simply forgotten.
                        state_q   <= ST_IDLE;
                        bit_cnt_q <= '0;
                        sdo_q     <= 1'b0;
                        skip_q    <= 1'b0;
                    end else if (sample_edge) begin
                        rx_sr_q <= rx_shifted;
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_q <= '0;
                            tx_sr_q   <= tx_data;
                            sdo_q     <= first_bit(tx_data);
                            skip_q    <= 1'b1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BW'(1);
                        end
                    end else if (shift_edge) begin
                        if (skip_q) begin
                            skip_q <= 1'b0;
                        end else begin
                            tx_sr_q <= tx_shifted;
                            sdo_q   <= first_bit(tx_shifted);
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign sdo  = sdo_q;
    assign busy = (state_q == ST_ACTIVE);

    // ------------------------------------------------------------------
    // RX FIFO (first-word fall-through)
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             pop, full, push_ok, ovf_set;

    assign rx_valid = (count_q != '0);
    assign full     = (count_q == FULL_CNT);
    assign pop      = rx_valid & rx_ready;
    // A pop in the same cycle frees the slot the push needs.
    assign push_ok  = word_done & (~full | pop);
    assign ovf_set  = word_done & full & ~pop;

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        overflow_d = overflow_q;
        if (ovf_clr) begin
            overflow_d = 1'b0;
        end else if (ovf_set) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: rx_data is forced to 0 whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= rx_shifted;
        end
    end

    assign rx_data  = rx_valid ? mem_q[rd_ptr_q] : '0;
    assign rx_count = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_spi_target_fifo.sv
// -----------------------------------------------------------------------------
// Bench for spi_target_fifo. There are four instances, one per SPI mode.
//   dut0: mode 0, MSB first
//   dut1: mode 1, LSB first
//   dut2: mode 2, LSB first
//   dut3: mode 3, LSB first
// A bit-level SPI controller drives each instance. The reference is a FIFO
// model made of plain arrays: words in, words out, plus a sticky overflow bit.
// A per-instance "settled" flag marks cycles with no transfer in flight. On
// every such cycle the compare process checks the DUT against the model.
// -----------------------------------------------------------------------------
module tb_spi_target_fifo;

    localparam int N    = 4;
    localparam int W    = 8;
    localparam int D    = 4;
    localparam int HALF = 8;   // sck half period in clk cycles

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   sck, sdi, ce, rx_ready, ovf_clr;
    logic [N-1:0]   sdo, rx_valid, overflow, busy;
    logic [W-1:0]   tx_data [N];
    logic [W-1:0]   rx_data [N];
    logic [2:0]     rx_count [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        spi_target_fifo #(
            .WIDTH(W), .DEPTH(D),
            .CPOL((g >= 2) ? 1 : 0),
            .CPHA(g % 2),
            .MSB_FIRST((g == 0) ? 1 : 0),
            .SYNC_STAGES(2)
        ) u_dut (
            .clk(clk), .reset(reset),
            .sck(sck[g]), .sdi(sdi[g]), .sdo(sdo[g]), .ce(ce[g]),
            .tx_data(tx_data[g]), .rx_data(rx_data[g]),
            .rx_valid(rx_valid[g]), .rx_ready(rx_ready[g]),
            .rx_count(rx_count[g]), .overflow(overflow[g]),
            .ovf_clr(ovf_clr[g]), .busy(busy[g])
        );
    end

    // ---------------- scoreboard state ----------------
    int           n_cmp = 0;
    int           n_bad = 0;
    logic [W-1:0] m_mem [N][D];
    int           m_cnt [N];
    logic         m_ovf [N];
    logic [N-1:0] settled;
    logic [W-1:0] got;

    function automatic logic f_cpol(input int d);
        return (d >= 2);
    endfunction
    function automatic logic f_cpha(input int d);
        return (d % 2) == 1;
    endfunction
    function automatic logic f_msb(input int d);
        return (d == 0);
    endfunction

    task automatic check(input string name, input int d, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at %0t",
                     name, d, act, exp, $time);
        end
    endtask

    task automatic m_push(input int d, input logic [W-1:0] w);
        if (m_cnt[d] < D) begin
            m_mem[d][m_cnt[d]] = w;
            m_cnt[d]++;
        end else begin
            m_ovf[d] = 1'b1;
        end
    endtask

    task automatic m_pop(input int d);
        for (int i = 0; i < D - 1; i++) m_mem[d][i] = m_mem[d][i+1];
        if (m_cnt[d] > 0) m_cnt[d]--;
    endtask

    task automatic m_reset();
        for (int d = 0; d < N; d++) begin
            m_cnt[d] = 0;
            m_ovf[d] = 1'b0;
            for (int i = 0; i < D; i++) m_mem[d][i] = '0;
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        for (int d = 0; d < N; d++) begin
            if (settled[d] && reset) begin
                check("count", d, rx_count[d], m_cnt[d]);
                check("valid", d, rx_valid[d], (m_cnt[d] != 0));
                check("data", d, rx_data[d], (m_cnt[d] != 0) ? m_mem[d][0] : 8'h00);
                check("ovf", d, overflow[d], m_ovf[d]);
                check("busy_idle", d, busy[d], 1'b0);
                check("sdo_idle", d, sdo[d], 1'b0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame_start(input int d);
        settled[d] = 1'b0;
        sck[d] = f_cpol(d);
        ce[d] = 1'b1;
        wait_clks(10);
    endtask

    task automatic frame_end(input int d);
        wait_clks(HALF);
        ce[d] = 1'b0;
        wait_clks(10);
        settled[d] = 1'b1;
    endtask

    // Drive nbits of b as the controller, capturing sdo at each sample edge.
    // The i-th captured sdo bit is stored at the position of the i-th sent bit,
    // so the captured word equals the DUT's tx_data. With pop_last set,
    // rx_ready is pulsed in exactly the cycle the DUT pushes the last word.
    task automatic xfer(input int d, input logic [W-1:0] b, input int nbits,
                        input logic pop_last, output logic [W-1:0] cap);
        int  idx;
        logic last;
        cap = '0;
        for (int i = 0; i < nbits; i++) begin
            idx  = f_msb(d) ? (W - 1 - i) : i;
            last = (i == W - 1) && pop_last;
            if (!f_cpha(d)) begin
                sdi[d] = b[idx];
                wait_clks(HALF);
                cap[idx] = sdo[d];
                sck[d] = ~f_cpol(d);
            end else begin
                sck[d] = ~f_cpol(d);
                sdi[d] = b[idx];
                wait_clks(HALF);
                cap[idx] = sdo[d];
                sck[d] = f_cpol(d);
            end
            if (last) begin
                // 2 synchroniser stages, then the edge is seen; push commits next edge.
                wait_clks(2);
                rx_ready[d] = 1'b1;
                wait_clks(1);
                rx_ready[d] = 1'b0;
                wait_clks(HALF - 3);
            end else begin
                wait_clks(HALF);
            end
            if (!f_cpha(d)) sck[d] = f_cpol(d);
        end
        if (nbits == W) begin
            if (pop_last) m_pop(d);
            m_push(d, b);
        end
    endtask

    task automatic pop_check(input int d, input logic [W-1:0] exp);
        settled[d] = 1'b0;
        check("pop_data", d, rx_data[d], exp);
        rx_ready[d] = 1'b1;
        wait_clks(1);
        rx_ready[d] = 1'b0;
        m_pop(d);
        settled[d] = 1'b1;
        wait_clks(1);
    endtask

    task automatic clear_ovf(input int d);
        settled[d] = 1'b0;
        ovf_clr[d] = 1'b1;
        wait_clks(1);
        ovf_clr[d] = 1'b0;
        m_ovf[d] = 1'b0;
        settled[d] = 1'b1;
        wait_clks(1);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "timeout");
    end

    // ---------------- main sequence ----------------
    initial begin
        reset = 1'b0;
        settled = '0;
        m_reset();
        for (int d = 0; d < N; d++) begin
            sck[d] = f_cpol(d);
            sdi[d] = 1'b0;
            ce[d] = 1'b0;
            rx_ready[d] = 1'b0;
            ovf_clr[d] = 1'b0;
            tx_data[d] = '0;
        end
        wait_clks(3);
        for (int d = 0; d < N; d++) begin
            check("rst_count", d, rx_count[d], 0);
            check("rst_valid", d, rx_valid[d], 0);
            check("rst_data", d, rx_data[d], 0);
            check("rst_ovf", d, overflow[d], 0);
            check("rst_busy", d, busy[d], 0);
            check("rst_sdo", d, sdo[d], 0);
        end
        reset = 1'b1;
        wait_clks(3);
        settled = '1;

        // Mode 0 single byte: receive 0xA5, transmit 0x3C (sdo 0,0,1,1,1,1,0,0).
        tx_data[0] = 8'h3C;
        frame_start(0);
        check("busy_active", 0, busy[0], 1'b1);
        xfer(0, 8'hA5, 8, 1'b0, got);
        frame_end(0);
        check("sdo_seq", 0, got, 8'h3C);
        check("rx_a5", 0, rx_data[0], 8'hA5);
        check("cnt_one", 0, rx_count[0], 1);
        pop_check(0, 8'hA5);

        // Modes 1..3, LSB first: 0x96 in, 0x5A out.
        for (int d = 1; d < N; d++) begin
            tx_data[d] = 8'h5A;
            frame_start(d);
            xfer(d, 8'h96, 8, 1'b0, got);
            frame_end(d);
            check("sdo_lsb", d, got, 8'h5A);
            check("rx_96", d, rx_data[d], 8'h96);
            pop_check(d, 8'h96);
        end

        // Modes 1..3: two back-to-back words in one frame.
        for (int d = 1; d < N; d++) begin
            tx_data[d] = 8'hC5;
            frame_start(d);
            xfer(d, 8'h12, 8, 1'b0, got);
            check("sdo_b2b0", d, got, 8'hC5);
            xfer(d, 8'h34, 8, 1'b0, got);
            check("sdo_b2b1", d, got, 8'hC5);
            frame_end(d);
            check("cnt_two", d, rx_count[d], 2);
            pop_check(d, 8'h12);
            pop_check(d, 8'h34);
        end

        // Five bytes into a 4-deep FIFO: fifth dropped, overflow set, then cleared.
        tx_data[0] = 8'h81;
        frame_start(0);
        for (int k = 1; k <= 5; k++) begin
            xfer(0, W'(k), 8, 1'b0, got);
            check("sdo_word", 0, got, 8'h81);
        end
        frame_end(0);
        check("cnt_full", 0, rx_count[0], 4);
        check("ovf_set", 0, overflow[0], 1'b1);
        check("head_01", 0, rx_data[0], 8'h01);
        clear_ovf(0);
        check("ovf_clr", 0, overflow[0], 1'b0);
        for (int k = 1; k <= 4; k++) pop_check(0, W'(k));
        check("empty", 0, rx_valid[0], 1'b0);

        // Partial word (5 bits) discarded, then a full 0x7E.
        for (int d = 0; d < N; d += 2) begin
            tx_data[d] = 8'h00;
            frame_start(d);
            xfer(d, 8'hFF, 5, 1'b0, got);
            frame_end(d);
            check("partial_cnt", d, rx_count[d], 0);
            frame_start(d);
            xfer(d, 8'h7E, 8, 1'b0, got);
            frame_end(d);
            check("cnt_7e", d, rx_count[d], 1);
            check("rx_7e", d, rx_data[d], 8'h7E);
            pop_check(d, 8'h7E);
        end

        // Full FIFO with a pop coinciding with the next push.
        frame_start(0);
        for (int k = 0; k < 4; k++) xfer(0, 8'h11 + W'(k), 8, 1'b0, got);
        xfer(0, 8'h15, 8, 1'b1, got);
        frame_end(0);
        check("cnt_pp", 0, rx_count[0], 4);
        check("ovf_pp", 0, overflow[0], 1'b0);
        for (int k = 2; k <= 5; k++) pop_check(0, 8'h10 + W'(k));

        // Reset in the middle of a word while one word is already held.
        tx_data[0] = 8'h0F;
        frame_start(0);
        xfer(0, 8'h5A, 8, 1'b0, got);
        xfer(0, 8'hFF, 3, 1'b0, got);
        settled = '0;
        reset = 1'b0;
        m_reset();
        #1;
        check("mid_rst_count", 0, rx_count[0], 0);
        check("mid_rst_valid", 0, rx_valid[0], 0);
        check("mid_rst_data", 0, rx_data[0], 0);
        check("mid_rst_busy", 0, busy[0], 0);
        check("mid_rst_sdo", 0, sdo[0], 0);
        check("mid_rst_ovf", 0, overflow[0], 0);
        ce[0] = 1'b0;
        sck[0] = f_cpol(0);
        wait_clks(4);
        reset = 1'b1;
        wait_clks(4);
        settled = '1;
        frame_start(0);
        xfer(0, 8'hC3, 8, 1'b0, got);
        frame_end(0);
        check("sdo_c3", 0, got, 8'h0F);
        check("cnt_c3", 0, rx_count[0], 1);
        check("rx_c3", 0, rx_data[0], 8'hC3);
        pop_check(0, 8'hC3);

        wait_clks(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
